// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external ALU between NREQ requesters.
// Round-robin grant, valid/ready handshake per requester, one registered
// response slot tagged with requester id and tag, and a saturating count
// of responses whose ALU result overflowed.
module alu_share_arb #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4,
    parameter int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_a,
    input  logic [NREQ*32-1:0]      req_b,
    input  logic [NREQ*4-1:0]       req_op,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic [3:0]              alu_op,
    input  logic [31:0]             alu_res,
    input  logic                    alu_zero,
    input  logic                    alu_less,
    input  logic                    alu_ovf,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [31:0]             rsp_data,
    output logic [2:0]              rsp_flags,
    output logic [15:0]             ovf_cnt
);

    logic               w_slot_free;
    logic               w_gnt_found;
    logic [IDW-1:0]     w_gnt_idx;
    logic [NREQ-1:0]    w_gnt_onehot;
    logic               w_fire;
    logic [IDW-1:0]     w_ptr_next;
    logic [TAG_W-1:0]   w_gnt_tag;

    logic [IDW-1:0]     r_rr_ptr;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [31:0]        r_rsp_data;
    logic [2:0]         r_rsp_flags;
    logic [15:0]        r_ovf_cnt;

    // (base + k) mod NREQ for base < NREQ and k < NREQ.
    function automatic int wrap_add(input int base, input int k);
        int sum;
        sum = base + k;
        if (sum >= NREQ) sum = sum - NREQ;
        return sum;
    endfunction

    // The slot can take a new result if empty or being drained this cycle.
    assign w_slot_free = ~r_rsp_valid | rsp_ready;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        w_gnt_found  = 1'b0;
        w_gnt_idx    = '0;
        w_gnt_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_found && req_valid[wrap_add(int'(r_rr_ptr), k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(wrap_add(int'(r_rr_ptr), k));
                w_gnt_onehot[wrap_add(int'(r_rr_ptr), k)] = 1'b1;
            end
        end
    end

    // Reset masks the handshake so nothing fires while the block is held in reset.
    assign req_ready = w_gnt_onehot & {NREQ{w_slot_free & ~rst}};
    assign w_fire    = w_gnt_found & w_slot_free & ~rst;

    // Drive the ALU from the granted slice; idle at zero so the ALU does not toggle.
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        w_gnt_tag = '0;
        if (w_gnt_found) begin
            alu_a     = req_a[32*int'(w_gnt_idx) +: 32];
            alu_b     = req_b[32*int'(w_gnt_idx) +: 32];
            alu_op    = req_op[4*int'(w_gnt_idx) +: 4];
            w_gnt_tag = req_tag[TAG_W*int'(w_gnt_idx) +: TAG_W];
        end
    end

    // Pointer moves to the requester after the one just served, wrapping.
    assign w_ptr_next = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + IDW'(1);

    // Response slot, round-robin pointer and saturating overflow counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_tag   <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_ovf_cnt   <= '0;
        end else if (w_fire) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_tag   <= w_gnt_tag;
            r_rsp_data  <= alu_res;
            r_rsp_flags <= {alu_ovf, alu_less, alu_zero};
            r_rr_ptr    <= w_ptr_next;
            if (alu_ovf && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: stimulus for alu_share_arb with a behavioural ALU stub
// and a transaction-level reference model of the arbiter and response slot.
module tb_alu_share_arb;

    localparam int NREQ  = 2;
    localparam int TAG_W = 4;
    localparam int IDW   = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*32-1:0]     req_a;
    logic [NREQ*32-1:0]     req_b;
    logic [NREQ*4-1:0]      req_op;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [31:0]            alu_a;
    logic [31:0]            alu_b;
    logic [3:0]             alu_op;
    logic [31:0]            alu_res;
    logic                   alu_zero;
    logic                   alu_less;
    logic                   alu_ovf;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [TAG_W-1:0]       rsp_tag;
    logic [31:0]            rsp_data;
    logic [2:0]             rsp_flags;
    logic [15:0]            ovf_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int               m_ptr;
    logic             m_valid;
    int               m_id;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_data;
    logic [2:0]       m_flags;
    int               m_cnt;

    always #5 clk = ~clk;

    alu_share_arb #(.NREQ(NREQ), .TAG_W(TAG_W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_less(alu_less), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .ovf_cnt(ovf_cnt)
    );

    // Behavioural ALU: returns {ovf, less, zero, result}.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [31:0] r;
        logic        o;
        logic        l;
        o = 1'b0;
        l = 1'b0;
        case (op)
            4'hE: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h6: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h7: begin l = ($signed(a) < $signed(b)); r = {31'd0, l}; end
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            default: r = a;
        endcase
        return {o, l, (r == 32'd0), r};
    endfunction

    assign {alu_ovf, alu_less, alu_zero, alu_res} = alu_fn(alu_a, alu_b, alu_op);

    // Requester chosen by round-robin from the model pointer, or -1.
    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        g = pick();
        if (g < 0 || rst || (m_valid && !rsp_ready)) return '0;
        return NREQ'(1) << g;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int g;
        logic [34:0] r;
        g = pick();
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_id = 0; m_tag = '0;
            m_data = '0; m_flags = '0; m_cnt = 0;
        end else if (g >= 0 && (!m_valid || rsp_ready)) begin
            r       = alu_fn(req_a[32*g +: 32], req_b[32*g +: 32], req_op[4*g +: 4]);
            m_valid = 1'b1;
            m_id    = g;
            m_tag   = req_tag[TAG_W*g +: TAG_W];
            m_data  = r[31:0];
            m_flags = r[34:32];
            if (r[34] && m_cnt < 65535) m_cnt++;
            m_ptr   = (g + 1) % NREQ;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 4'hE;
            1: return 4'h6;
            2: return 4'h7;
            3: return 4'h0;
            4: return 4'h1;
            5: return 4'h2;
            default: return 4'h3;
        endcase
    endfunction

    task automatic load_req(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [TAG_W-1:0] tag);
        req_a[32*i +: 32]       = a;
        req_b[32*i +: 32]       = b;
        req_op[4*i +: 4]        = op;
        req_tag[TAG_W*i +: TAG_W] = tag;
        req_valid[i]            = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b1;
        clk_edge();
        clk_edge();
        #1;
        total++;
        if ({rsp_valid, ovf_cnt} !== 17'd0) begin
            bad++; $display("FAIL reset_state got valid=%b cnt=%h exp 0/0", rsp_valid, ovf_cnt);
        end
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== 68'd0) begin
            bad++; $display("FAIL reset_alu got a=%h b=%h op=%h exp 0", alu_a, alu_b, alu_op);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        load_req(0, 32'd5, 32'd7, 4'hE, 4'd3);
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL single_ready got=%b exp=01", req_ready);
        end
        clk_edge();
        req_valid = '0;
        total++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_flags} !== {1'b1, 32'd12, 1'b0, 4'd3, 3'b000}) begin
            bad++; $display("FAIL single_rsp got v=%b d=%0d id=%0d tag=%0d f=%b exp v=1 d=12 id=0 tag=3 f=000",
                            rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_flags);
        end
        clk_edge();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_drain got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_alternate();
        int served[NREQ];
        int prev;
        for (int i = 0; i < NREQ; i++) served[i] = 0;
        prev = -1;
        for (int i = 0; i < NREQ; i++) load_req(i, rnd_word(), rnd_word(), rnd_op(), 4'($urandom));
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [NREQ-1:0] er;
            int g;
            #1;
            er = exp_ready();
            g  = pick();
            total++;
            if (req_ready !== er || g == prev) begin
                bad++; $display("FAIL alt_grant cyc=%0d got=%b exp=%b prev=%0d", c, req_ready, er, prev);
            end
            prev = g;
            served[g]++;
            clk_edge();
            total++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, IDW'(m_id), m_data}) begin
                bad++; $display("FAIL alt_rsp cyc=%0d got id=%0d d=%h exp id=%0d d=%h",
                                c, rsp_id, rsp_data, m_id, m_data);
            end
            load_req(g, rnd_word(), rnd_word(), rnd_op(), 4'($urandom));
        end
        total++;
        if (served[0] != 4 || served[1] != 4) begin
            bad++; $display("FAIL alt_fair got %0d/%0d exp 4/4", served[0], served[1]);
        end
    endtask

    task automatic test_stall();
        int nxt;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== '0) begin
                bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, req_ready);
            end
            clk_edge();
            total++;
            if ({rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags} !==
                {1'b1, IDW'(m_id), m_tag, m_data, m_flags}) begin
                bad++; $display("FAIL stall_hold cyc=%0d got id=%0d tag=%h d=%h f=%b exp id=%0d tag=%h d=%h f=%b",
                                c, rsp_id, rsp_tag, rsp_data, rsp_flags, m_id, m_tag, m_data, m_flags);
            end
        end
        nxt = (m_id + 1) % NREQ;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== (NREQ'(1) << nxt)) begin
            bad++; $display("FAIL stall_release got=%b exp requester %0d", req_ready, nxt);
        end
        clk_edge();
        req_valid = '0;
        clk_edge();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            logic [NREQ-1:0] er;
            logic [67:0]     ealu;
            int g;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) != 0)
                    load_req(i, rnd_word(), rnd_word(), rnd_op(), 4'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            g  = pick();
            ealu = (g < 0) ? 68'd0 : {req_a[32*g +: 32], req_b[32*g +: 32], req_op[4*g +: 4]};
            total++;
            if (req_ready !== er) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, er);
            end
            total++;
            if ({alu_a, alu_b, alu_op} !== ealu) begin
                bad++; $display("FAIL rnd_alu cyc=%0d got=%h exp=%h", c, {alu_a, alu_b, alu_op}, ealu);
            end
            clk_edge();
            total++;
            if ({rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags, ovf_cnt} !==
                {m_valid, IDW'(m_id), m_tag, m_data, m_flags, 16'(m_cnt)}) begin
                bad++; $display("FAIL rnd_rsp cyc=%0d got v=%b id=%0d tag=%h d=%h f=%b cnt=%0d exp v=%b id=%0d tag=%h d=%h f=%b cnt=%0d",
                                c, rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags, ovf_cnt,
                                m_valid, m_id, m_tag, m_data, m_flags, m_cnt);
            end
            req_valid = req_valid & ~er;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        clk_edge();
    endtask

    task automatic test_reset_inflight();
        load_req(0, 32'd9, 32'd4, 4'h6, 4'd6);
        rsp_ready = 1'b1;
        clk_edge();
        load_req(0, 32'd1, 32'd2, 4'hE, 4'd7);
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            bad++; $display("FAIL rstfly_pre got v=%b ready=%b exp v=1 ready=0", rsp_valid, req_ready);
        end
        clk_edge();
        total++;
        if ({rsp_valid, rsp_data, rsp_tag, ovf_cnt} !== 53'd0) begin
            bad++; $display("FAIL rstfly_drop got v=%b d=%h tag=%h cnt=%h exp all 0",
                            rsp_valid, rsp_data, rsp_tag, ovf_cnt);
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        clk_edge();
    endtask

    task automatic test_overflow();
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        load_req(1, 32'h7FFF_FFFF, 32'd1, 4'hE, 4'd5);
        rsp_ready = 1'b1;
        #1;
        clk_edge();
        total++;
        if ({rsp_valid, rsp_id, rsp_flags[2], ovf_cnt} !== {1'b1, 1'b1, 1'b1, 16'd1}) begin
            bad++; $display("FAIL ovf_first got v=%b id=%0d ovf=%b cnt=%0d exp 1/1/1/1",
                            rsp_valid, rsp_id, rsp_flags[2], ovf_cnt);
        end
        for (int c = 0; c < 65536; c++) begin
            clk_edge();
            if (m_cnt >= 65533) begin
                total++;
                if (ovf_cnt !== 16'(m_cnt)) begin
                    bad++; $display("FAIL ovf_near_sat cyc=%0d got=%h exp=%h", c, ovf_cnt, 16'(m_cnt));
                end
            end
        end
        total++;
        if (ovf_cnt !== 16'hFFFF || rsp_valid !== 1'b1) begin
            bad++; $display("FAIL ovf_saturate got cnt=%h v=%b exp cnt=ffff v=1", ovf_cnt, rsp_valid);
        end
        req_valid = '0;
        clk_edge();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_random();
        test_reset_inflight();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
